// File: rtl/uart_cmd_packer_pkg.sv
// Shared types and sizing helpers for the UART command packer and related stream blocks.
package uart_cmd_pkg;

    // Packer framing state: IDLE holds no bytes, COLLECT holds a partial word
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } pack_state_e;

    // Width of a counter that indexes 0..n-1 (never narrower than one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Command word width for a given byte count
    function automatic int unsigned data_width(input int unsigned bytes);
        return 8 * bytes;
    endfunction

endpackage

// File: rtl/uart_cmd_packer_if.sv
// UART read side and command stream side of the packer, bundled as one interface.
interface uart_cmd_packer_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEVEL_W = 4
);
    logic              rx_rd_o;
    logic              rx_valid_i;
    logic              rx_busy_i;
    logic [7:0]        rx_data_i;
    logic              cmd_axis_tvalid_o;
    logic              cmd_axis_tready_i;
    logic [DATA_W-1:0] cmd_axis_tdata_o;
    logic [LEVEL_W-1:0] level_o;
    logic              timeout_o;
    logic              overflow_stall_o;

    // Packer side
    modport master (
        output rx_rd_o,
        input  rx_valid_i,
        input  rx_busy_i,
        input  rx_data_i,
        output cmd_axis_tvalid_o,
        input  cmd_axis_tready_i,
        output cmd_axis_tdata_o,
        output level_o,
        output timeout_o,
        output overflow_stall_o
    );

    // UART and command sink side
    modport slave (
        input  rx_rd_o,
        output rx_valid_i,
        output rx_busy_i,
        output rx_data_i,
        input  cmd_axis_tvalid_o,
        output cmd_axis_tready_i,
        input  cmd_axis_tdata_o,
        input  level_o,
        input  timeout_o,
        input  overflow_stall_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_ni,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // An empty FIFO presents zero rather than whatever stale word sits at the read pointer
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Word storage is data only and carries no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_cmd_packer.sv
// Packs UART bytes into command words, queues them in a FIFO, and drops stale partial words.
module uart_cmd_packer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BYTES          = 4,
    parameter int unsigned DEPTH          = 8,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset_ni,
    uart_cmd_packer_if.master bus
);
    localparam int unsigned DATA_W  = data_width(BYTES);
    localparam int unsigned CNT_W   = cnt_width(BYTES);
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;
    localparam int unsigned TO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    pack_state_e        state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]    to_cnt_q;
    logic               timeout_q;
    logic [DATA_W-1:0]  asm_q, word_next, fifo_data;
    logic               rd_gate, accept, push, expire, to_hit;
    logic               fifo_full, fifo_empty;
    logic [LEVEL_W-1:0] fifo_level;

    // Merge one byte into the word under assembly at position idx
    function automatic logic [DATA_W-1:0] assemble(input logic [DATA_W-1:0] cur,
                                                   input logic [7:0]        b,
                                                   input logic [CNT_W-1:0]  idx);
        logic [DATA_W-1:0] w;
        if (MSB_FIRST) begin
            // Older bytes slide up; anything left over from a previous word shifts out
            w = (cur << 8) | DATA_W'(b);
        end else begin
            w = cur;
            for (int k = 0; k < BYTES; k++) begin
                if (idx == CNT_W'(k)) w[8*k +: 8] = b;
            end
        end
        return w;
    endfunction

    // Only the word-completing byte waits for FIFO space; a pop in the same cycle does not help
    assign rd_gate   = (byte_cnt_q != LAST_IDX) || !fifo_full;
    assign accept    = rd_gate && bus.rx_valid_i && !bus.rx_busy_i;
    assign to_hit    = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);
    assign word_next = assemble(asm_q, bus.rx_data_i, byte_cnt_q);

    // Framing state and byte position register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Next framing state: advance on accepted bytes, push on completion, drop on timeout
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        push       = 1'b0;
        expire     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (BYTES == 1) begin
                        push = 1'b1;
                    end else begin
                        byte_cnt_d = CNT_W'(1);
                        state_d    = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (byte_cnt_q == LAST_IDX) begin
                        push       = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (to_hit) begin
                    // A stalled completing byte also ages here, so sink back-pressure can drop a word
                    expire     = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                byte_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Inter-byte idle counter: runs only while a partial word is held
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            to_cnt_q <= '0;
        end else if (accept || expire || state_q == IDLE) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // One-cycle discard pulse, registered off the expiry decision
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) timeout_q <= 1'b0;
        else           timeout_q <= expire;
    end

    // Word under assembly; every lane is rewritten before use, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) asm_q <= word_next;
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_ni  (reset_ni),
        .push      (push),
        .push_data (word_next),
        .pop       (bus.cmd_axis_tready_i),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bus.rx_rd_o           = rd_gate;
    assign bus.cmd_axis_tvalid_o = !fifo_empty;
    assign bus.cmd_axis_tdata_o  = fifo_data;
    assign bus.level_o           = fifo_level;
    assign bus.timeout_o         = timeout_q;
    assign bus.overflow_stall_o  = (byte_cnt_q == LAST_IDX) && fifo_full &&
                                   bus.rx_valid_i && !bus.rx_busy_i;

endmodule

// File: tb/tb_uart_cmd_packer.sv
// Bench for uart_cmd_packer: directed scenarios plus random traffic against a queue-based model.
module tb_uart_cmd_packer;
    localparam int BYTES = 4;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_packer_if #(.DATA_W(32), .LEVEL_W(4)) ifa ();
    uart_cmd_packer_if #(.DATA_W(32), .LEVEL_W(4)) ifb ();
    uart_cmd_packer_if #(.DATA_W(16), .LEVEL_W(4)) ifc ();

    uart_cmd_packer #(.BYTES(4), .DEPTH(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .reset_ni(reset_ni), .bus(ifa));
    uart_cmd_packer #(.BYTES(4), .DEPTH(8), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset_ni(reset_ni), .bus(ifb));
    uart_cmd_packer #(.BYTES(2), .DEPTH(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(0)) dut_c (
        .clk(clk), .reset_ni(reset_ni), .bus(ifc));

    // Secondary configurations see the same byte stream and never back-pressure
    assign ifb.rx_valid_i        = ifa.rx_valid_i;
    assign ifb.rx_busy_i         = ifa.rx_busy_i;
    assign ifb.rx_data_i         = ifa.rx_data_i;
    assign ifb.cmd_axis_tready_i = 1'b1;
    assign ifc.rx_valid_i        = ifa.rx_valid_i;
    assign ifc.rx_busy_i         = ifa.rx_busy_i;
    assign ifc.rx_data_i         = ifa.rx_data_i;
    assign ifc.cmd_axis_tready_i = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  part[$];
    logic [31:0] mq[$];
    int          idle_cnt = 0;
    bit          to_pend  = 1'b0;

    // Observation and capture
    bit          obs_tvalid, obs_to, obs_stall;
    logic [31:0] obs_tdata;
    logic [3:0]  obs_level;
    bit          cap_en = 1'b0;
    bit          rec_pop = 1'b0;
    logic [31:0] capb[$];
    logic [15:0] capc[$];
    logic [31:0] popped[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock of stimulus: drive, compare against the model, then advance the model
    task automatic step(input bit v, input bit bz, input logic [7:0] d, input bit tr, output bit acc);
        bit e_full, e_rd, e_stall, e_tv, expire, pop;
        logic [31:0] w;
        @(negedge clk);
        ifa.rx_valid_i = v;
        ifa.rx_busy_i = bz;
        ifa.rx_data_i = d;
        ifa.cmd_axis_tready_i = tr;
        #1;
        e_full  = (mq.size() == DEPTH);
        e_rd    = (part.size() != BYTES - 1) || !e_full;
        e_stall = (part.size() == BYTES - 1) && e_full && v && !bz;
        e_tv    = (mq.size() != 0);
        check_val("rx_rd", 64'(ifa.rx_rd_o), 64'(e_rd));
        check_val("tvalid", 64'(ifa.cmd_axis_tvalid_o), 64'(e_tv));
        if (e_tv) check_val("tdata", 64'(ifa.cmd_axis_tdata_o), 64'(mq[0]));
        check_val("level", 64'(ifa.level_o), 64'(mq.size()));
        check_val("timeout", 64'(ifa.timeout_o), 64'(to_pend));
        check_val("ovf_stall", 64'(ifa.overflow_stall_o), 64'(e_stall));
        obs_tvalid = ifa.cmd_axis_tvalid_o;
        obs_tdata  = ifa.cmd_axis_tdata_o;
        obs_level  = ifa.level_o;
        obs_to     = ifa.timeout_o;
        obs_stall  = ifa.overflow_stall_o;
        if (cap_en && ifb.cmd_axis_tvalid_o) capb.push_back(ifb.cmd_axis_tdata_o);
        if (cap_en && ifc.cmd_axis_tvalid_o) capc.push_back(ifc.cmd_axis_tdata_o);
        if (rec_pop && ifa.cmd_axis_tvalid_o && tr) popped.push_back(ifa.cmd_axis_tdata_o);

        acc    = e_rd && v && !bz;
        pop    = e_tv && tr;
        expire = (part.size() > 0) && !acc && (idle_cnt == TMO - 1);
        to_pend = expire;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            part.push_back(d);
            idle_cnt = 0;
            if (part.size() == BYTES) begin
                w = '0;
                foreach (part[i]) w = {w[23:0], part[i]};
                mq.push_back(w);
                part.delete();
            end
        end else if (expire) begin
            part.delete();
            idle_cnt = 0;
        end else if (part.size() > 0) begin
            idle_cnt++;
        end else begin
            idle_cnt = 0;
        end
    endtask

    // UART behaviour: hold the byte until read, then drop valid for a cycle
    task automatic send_byte(input logic [7:0] d, input bit tr);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            step(1'b1, 1'b0, d, tr, acc);
            n++;
        end
        check_val("byte_accept", 64'(acc), 64'(1));
        step(1'b0, 1'b0, 8'h00, tr, acc);
    endtask

    task automatic idle(input int n, input bit tr);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, tr, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        ifa.rx_valid_i = 1'b0;
        ifa.rx_busy_i = 1'b0;
        ifa.cmd_axis_tready_i = 1'b0;
        #1;
        check_val("rst_rx_rd", 64'(ifa.rx_rd_o), 64'(1));
        check_val("rst_tvalid", 64'(ifa.cmd_axis_tvalid_o), 64'(0));
        check_val("rst_tdata", 64'(ifa.cmd_axis_tdata_o), 64'(0));
        check_val("rst_level", 64'(ifa.level_o), 64'(0));
        check_val("rst_timeout", 64'(ifa.timeout_o), 64'(0));
        check_val("rst_stall", 64'(ifa.overflow_stall_o), 64'(0));
        part.delete();
        mq.delete();
        idle_cnt = 0;
        to_pend = 1'b0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_to;
        bit acc, v, bz, tr;
        logic [7:0] d;
        int gap, tr_pct;
        logic [31:0] ew;

        ifa.rx_valid_i = 1'b0;
        ifa.rx_busy_i = 1'b0;
        ifa.rx_data_i = 8'h00;
        ifa.cmd_axis_tready_i = 1'b0;
        do_reset();

        // Byte order and latency on all three configurations
        cap_en = 1'b1;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        check_val("lat_tvalid", 64'(obs_tvalid), 64'(1));
        check_val("msb_word", 64'(obs_tdata), 64'h12345678);
        idle(3, 1'b1);
        cap_en = 1'b0;
        check_val("lsb_count", 64'(capb.size()), 64'(1));
        if (capb.size() > 0) check_val("lsb_word", 64'(capb[0]), 64'h78563412);
        check_val("b2_count", 64'(capc.size()), 64'(2));
        if (capc.size() > 1) begin
            check_val("b2_word0", 64'(capc[0]), 64'h1234);
            check_val("b2_word1", 64'(capc[1]), 64'h5678);
        end

        // Stale partial word is dropped after the idle timeout
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        cnt_to = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, acc);
            cnt_to += int'(obs_to);
        end
        check_val("to_pulses", 64'(cnt_to), 64'(1));
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check_val("resync_word", 64'(obs_tdata), 64'h01020304);
        idle(3, 1'b1);

        // Fill the FIFO, stall the completing byte, then drain in order
        for (int i = 0; i < 35; i++) send_byte(8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd35, 1'b0, acc);
        check_val("full_level", 64'(obs_level), 64'(8));
        check_val("full_stall", 64'(obs_stall), 64'(1));
        popped.delete();
        rec_pop = 1'b1;
        send_byte(8'd35, 1'b1);
        idle(12, 1'b1);
        rec_pop = 1'b0;
        check_val("drain_count", 64'(popped.size()), 64'(9));
        for (int k = 0; k < popped.size(); k++) begin
            ew = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            check_val("drain_word", 64'(popped[k]), 64'(ew));
        end

        // Push and pop in the same cycle at level 3
        for (int i = 0; i < 15; i++) send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        check_val("pushpop_level", 64'(obs_level), 64'(3));
        idle(12, 1'b1);

        // Pointer wrap over three FIFO depths with random back-pressure
        for (int i = 0; i < 3 * DEPTH * BYTES; i++) send_byte(8'($urandom), 1'($urandom % 2));
        idle(20, 1'b1);

        // Reset with a partial word and two queued words
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
        do_reset();
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hD4, 1'b1);
        check_val("post_rst_word", 64'(obs_tdata), 64'hA1B2C3D4);
        idle(3, 1'b1);

        // Random traffic with gaps, busy cycles, back-pressure phases and occasional resets
        v = 1'b0; d = 8'h00; acc = 1'b0; gap = 0; tr_pct = 85;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) tr_pct = ($urandom % 2 == 1) ? 85 : 15;
            if (gap > 0) gap--;
            else if ($urandom % 150 == 0) gap = int'($urandom_range(10, 25));
            if (acc) v = 1'b0;
            else if (!v && gap == 0) begin
                v = ($urandom % 3) != 0;
                d = 8'($urandom);
            end
            bz = ($urandom % 6) == 0;
            tr = int'($urandom % 100) < tr_pct;
            if ($urandom % 1500 == 0) begin
                do_reset();
                v = 1'b0;
            end
            step(v, bz, d, tr, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_packer.md
# uart_cmd_packer

Parametrised byte-to-word command packer between the UART receiver and any AXI-stream command sink (graphite command port). It pulls bytes from the UART read interface and assembles them into BYTES-wide words in a selectable byte order. Completed words are buffered in a DEPTH-entry FIFO so UART reads never wait on sink back-pressure. An inter-byte timeout discards a stale partial word and resynchronises framing.

## Interface
- BYTES, 4: bytes per command word; DATA_W = 8*BYTES; legal 1..8
- DEPTH, 8: FIFO entries; power of two, >= 2
- MSB_FIRST, 1: 1 = first byte lands in DATA_W-1:DATA_W-8; 0 = first byte lands in 7:0
- TIMEOUT_CYCLES, 250000: idle cycles tolerated mid-word; 0 disables timeout
- clk  in  1  single clock for the whole block
- reset_ni  in  1  asynchronous, active-low reset
- rx_rd_o  out  1  read request to UART
- rx_valid_i  in  1  UART holds a received byte
- rx_busy_i  in  1  UART busy; no byte may be taken
- rx_data_i  in  8  received byte
- cmd_axis_tvalid_o  out  1  FIFO head valid
- cmd_axis_tready_i  in  1  sink accepts head
- cmd_axis_tdata_o  out  DATA_W  FIFO head word
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- timeout_o  out  1  one-cycle pulse: partial word discarded
- overflow_stall_o  out  1  high while a completing byte is blocked by full FIFO

## Operation
- Byte accepted in a cycle where rx_rd_o && rx_valid_i && !rx_busy_i; UART contract: valid drops the cycle after an accepted read.
- rx_rd_o = (byte_cnt != BYTES-1) || !full. Partial bytes always accepted; only the completing byte waits for space. Full-and-pop in same cycle does not open the gate (no bypass).
- States: IDLE (byte_cnt=0), COLLECT (0<byte_cnt<BYTES).
  - IDLE: accepted byte -> byte_cnt=1, COLLECT (BYTES=1: pushes directly, stays IDLE).
  - COLLECT: accepted byte -> byte_cnt+1; if it completes the word: push {assembled, byte} into FIFO, byte_cnt=0, IDLE.
  - COLLECT: timeout expiry -> partial word dropped, byte_cnt=0, timeout_o pulse, IDLE.
- Assembly: MSB_FIRST=1 shift left by 8 inserting at [7:0]; MSB_FIRST=0 write byte k into [8k+7:8k].
- Timeout counter: cleared on every accepted byte and in IDLE; counts in COLLECT; expiry when count == TIMEOUT_CYCLES-1. Stalled completing byte still counts (sink stall can cause drop; intended).
- FIFO: pop when tvalid && tready; push and pop in the same cycle leave level unchanged; pointers wrap modulo DEPTH.
- overflow_stall_o = (byte_cnt == BYTES-1) && full && rx_valid_i && !rx_busy_i.

## Timing
- Reset (async assert, sync release): rx_rd_o=1, cmd_axis_tvalid_o=0, cmd_axis_tdata_o=0, level_o=0, timeout_o=0, overflow_stall_o=0, byte_cnt=0, state IDLE, timeout counter 0, FIFO pointers 0.
- Reset mid-word or with FIFO contents: everything discarded, no output glitch beyond tvalid dropping.
- Latency: completing byte accepted in cycle N -> word at FIFO head, tvalid high in N+1 (if FIFO was empty). tdata read combinationally from registered storage at read pointer; stable while tvalid && !tready.
- level_o registered; updates the cycle after push/pop.
- timeout_o high exactly one cycle, the cycle after expiry.
- Full asserted when level == DEPTH; deasserts the cycle after a pop.

## Structure
- Shared package uart_cmd_pkg: state enum (IDLE, COLLECT), byte-count width function, DATA_W derivation helper.
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level), reusable by the framebuffer stream path.
- Packer FSM, assembler and timeout counter live in uart_cmd_packer.

## Test plan
- BYTES=4, MSB_FIRST=1, tready=1: bytes 12 34 56 78 -> one beat tdata=32'h12345678, tvalid one cycle after 4th byte accepted.
- MSB_FIRST=0 same bytes -> tdata=32'h78563412; BYTES=2 -> words 16'h1234, 16'h5678.
- tready=0, DEPTH=8, 36 bytes -> level_o=8, 33rd..35th bytes accepted, 36th stalled with overflow_stall_o=1; raise tready -> 9 words out in order, no loss.
- TIMEOUT_CYCLES=16: bytes AA BB, wait 20 cycles -> timeout_o single pulse, then 01 02 03 04 -> tdata=32'h01020304 (AA BB dropped).
- Simultaneous push and pop at level 3 -> level stays 3; pointer wrap across 3×DEPTH words keeps order.
- reset_ni low mid-word with 2 words queued -> tvalid=0, level_o=0 immediately; after release next 4 bytes form a fresh word.
